// File: rtl/keypad_entry.sv
// keypad_entry
//   Turns 16 debounced key levels into discrete key events and a BCD entry
//   buffer of up to DIGITS digits. A press is accepted only when the keypad
//   goes from fully released to exactly one key down. A chord is rejected.
//   Nothing further happens until every key has been released again.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   key_link     debounced key levels (0-9 digits, 10 backspace, 11 clear,
//                12-14 function keys, 15 enter)
//   key_valid    one-cycle pulse per accepted press
//   key_code     index of the last accepted key (held between pulses)
//   key_err      one-cycle pulse on a chord or on a digit with a full buffer
//   digits       current BCD buffer, [3:0] is the most recent digit
//   count        number of digits held, 0..DIGITS
//   entry_valid  one-cycle pulse on enter
//   entry_value  buffer captured at enter (held until the next enter)
//   entry_count  count captured at enter
//
// Every output is registered, so there is no combinational path from
// key_link to any output.
module keypad_entry #(
  parameter int DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_link,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_err,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic        entry_valid,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_count
);

  // Nibbles above the configured depth always read as zero.
  localparam logic [15:0] DIGIT_MASK =
    (DIGITS >= 4) ? 16'hFFFF : 16'((32'd1 << (4 * DIGITS)) - 32'd1);
  localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

  localparam logic [3:0] KEY_BACKSPACE = 4'd10;
  localparam logic [3:0] KEY_CLEAR     = 4'd11;
  localparam logic [3:0] KEY_ENTER     = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t state_reg;

  // A one-hot test decides between accept and reject. The index is
  // built by OR-ing the indices of all set bits. That value is only
  // meaningful when exactly one bit is set, and it is only used in that
  // case, so chords are never priority-encoded.
  logic       any_key;
  logic       one_hot;
  logic [3:0] key_idx;
  logic [3:0] idx_terms [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_idx
      assign idx_terms[gi] = key_link[gi] ? 4'(gi) : 4'h0;
    end
  endgenerate

  always_comb begin
    key_idx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      key_idx = key_idx | idx_terms[i];
    end
  end

  assign any_key = (key_link != 16'h0);
  assign one_hot = any_key && ((key_link & (key_link - 16'd1)) == 16'h0);

  // Reset lands in HELD. A key held through reset is therefore ignored
  // until the keypad has been fully released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= HELD;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      key_err     <= 1'b0;
      digits      <= 16'h0;
      count       <= 3'd0;
      entry_valid <= 1'b0;
      entry_value <= 16'h0;
      entry_count <= 3'd0;
    end else begin
      key_valid   <= 1'b0;
      key_err     <= 1'b0;
      entry_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (any_key) begin
            state_reg <= HELD;
            if (one_hot) begin
              key_valid <= 1'b1;
              key_code  <= key_idx;
              if (key_idx <= 4'd9) begin
                // The key is still reported when the buffer is full,
                // and it is also flagged as an error.
                if (count < MAX_COUNT) begin
                  digits <= {digits[11:0], key_idx} & DIGIT_MASK;
                  count  <= count + 3'd1;
                end else begin
                  key_err <= 1'b1;
                end
              end else begin
                case (key_idx)
                  KEY_BACKSPACE: begin
                    // Backspace on an empty buffer is a silent no-op.
                    if (count != 3'd0) begin
                      digits <= {4'h0, digits[15:4]};
                      count  <= count - 3'd1;
                    end
                  end
                  KEY_CLEAR: begin
                    digits <= 16'h0;
                    count  <= 3'd0;
                  end
                  KEY_ENTER: begin
                    // Capture the buffer as it was before the clear.
                    entry_value <= digits;
                    entry_count <= count;
                    entry_valid <= 1'b1;
                    digits      <= 16'h0;
                    count       <= 3'd0;
                  end
                  default: begin
                    // Function keys only report key_valid and key_code.
                  end
                endcase
              end
            end else begin
              key_err <= 1'b1;
            end
          end
        end

        HELD: begin
          // Changes while keys are down are ignored, so there is no
          // rollover.
          if (!any_key) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= HELD;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//   Scoreboard bench for keypad_entry. Each directed press pushes its
//   hand-computed expected event, tagged with the cycle on which it must
//   appear, into a queue. A separate monitor pops and compares the queue
//   whenever the DUT shows key_valid, key_err or entry_valid.
module tb_keypad_entry;

  logic        clk;
  logic        rst;
  logic [15:0] key_link;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_err;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;

  keypad_entry #(.DIGITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_link    (key_link),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_err     (key_err),
    .digits      (digits),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .entry_count (entry_count)
  );

  typedef struct packed {
    logic        kv;
    logic        ke;
    logic [3:0]  code;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        ev;
    logic [15:0] evalue;
    logic [2:0]  ecnt;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t obs;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic kv, input logic ke, input logic [3:0] code,
                              input logic [15:0] dig, input logic [2:0] cnt,
                              input logic ev, input logic [15:0] evalue,
                              input logic [2:0] ecnt);
    obs_t o;
    o.kv = kv; o.ke = ke; o.code = code; o.dig = dig; o.cnt = cnt;
    o.ev = ev; o.evalue = evalue; o.ecnt = ecnt;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(key_valid, key_err, key_code, digits, count,
              entry_valid, entry_value, entry_count);
  endfunction

  // Monitor: any output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (key_valid || key_err || entry_valid)) begin
      obs_t act;
      act = sample();
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_event cyc=%0d got=%h required=no event", cyc, act);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (act !== e.obs || cyc != e.cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL %s got=%h@%0d required=%h@%0d", e.name, act, cyc, e.obs, e.cyc);
        end else begin
          $display("ok   %s cyc=%0d obs=%h", e.name, cyc, act);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    obs_t act;
    act = sample();
    n_cmp = n_cmp + 1;
    if (act !== '0) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h required=0", name, act);
    end else begin
      $display("ok   %s outputs all zero", name);
    end
  endtask

  // Press one vector on a falling edge, hold it, release it, and leave
  // two released cycles so the next press starts from IDLE.
  task automatic press(input string name, input logic [15:0] vec, input int hold,
                       input obs_t o);
    exp_t e;
    @(negedge clk);
    key_link = vec;
    e.cyc  = cyc + 1;
    e.obs  = o;
    e.name = name;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    key_link = 16'h0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    rst      = 1'b1;
    key_link = 16'h0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the buffer with 1234, then enter.
    press("d1", 16'h0002, 5, mk(1, 0, 4'd1, 16'h0001, 3'd1, 0, 16'h0000, 3'd0));
    press("d2", 16'h0004, 5, mk(1, 0, 4'd2, 16'h0012, 3'd2, 0, 16'h0000, 3'd0));
    press("d3", 16'h0008, 5, mk(1, 0, 4'd3, 16'h0123, 3'd3, 0, 16'h0000, 3'd0));
    press("d4", 16'h0010, 5, mk(1, 0, 4'd4, 16'h1234, 3'd4, 0, 16'h0000, 3'd0));
    press("enter_1234", 16'h8000, 5, mk(1, 0, 4'd15, 16'h0000, 3'd0, 1, 16'h1234, 3'd4));

    // Overflow: the fifth digit reports both valid and error.
    press("d5", 16'h0020, 5, mk(1, 0, 4'd5, 16'h0005, 3'd1, 0, 16'h1234, 3'd4));
    press("d6", 16'h0040, 5, mk(1, 0, 4'd6, 16'h0056, 3'd2, 0, 16'h1234, 3'd4));
    press("d7", 16'h0080, 5, mk(1, 0, 4'd7, 16'h0567, 3'd3, 0, 16'h1234, 3'd4));
    press("d8", 16'h0100, 5, mk(1, 0, 4'd8, 16'h5678, 3'd4, 0, 16'h1234, 3'd4));
    press("d9_full", 16'h0200, 5, mk(1, 1, 4'd9, 16'h5678, 3'd4, 0, 16'h1234, 3'd4));
    press("clear", 16'h0800, 3, mk(1, 0, 4'd11, 16'h0000, 3'd0, 0, 16'h1234, 3'd4));

    // Backspace down to an empty buffer and one step past it.
    press("bs_d7", 16'h0080, 3, mk(1, 0, 4'd7, 16'h0007, 3'd1, 0, 16'h1234, 3'd4));
    press("bs_d3", 16'h0008, 3, mk(1, 0, 4'd3, 16'h0073, 3'd2, 0, 16'h1234, 3'd4));
    press("bs_1", 16'h0400, 3, mk(1, 0, 4'd10, 16'h0007, 3'd1, 0, 16'h1234, 3'd4));
    press("bs_2", 16'h0400, 3, mk(1, 0, 4'd10, 16'h0000, 3'd0, 0, 16'h1234, 3'd4));
    press("bs_empty", 16'h0400, 3, mk(1, 0, 4'd10, 16'h0000, 3'd0, 0, 16'h1234, 3'd4));

    // Chord: error only, key_code keeps the last accepted key.
    press("chord_2_5", 16'h0024, 4, mk(0, 1, 4'd10, 16'h0000, 3'd0, 0, 16'h1234, 3'd4));

    // No rollover: holding 4 and then adding 6 gives a single event for 4.
    begin
      exp_t e;
      @(negedge clk);
      key_link = 16'h0010;
      e.cyc  = cyc + 1;
      e.obs  = mk(1, 0, 4'd4, 16'h0004, 3'd1, 0, 16'h1234, 3'd4);
      e.name = "rollover_4";
      exp_q.push_back(e);
      repeat (3) @(negedge clk);
      key_link = 16'h0050;
      repeat (3) @(negedge clk);
      key_link = 16'h0040;
      repeat (2) @(negedge clk);
      key_link = 16'h0000;
      repeat (2) @(negedge clk);
    end

    // A function key leaves the buffer alone. Then enter at count 1 and
    // enter at count 0.
    press("fn13", 16'h2000, 3, mk(1, 0, 4'd13, 16'h0004, 3'd1, 0, 16'h1234, 3'd4));
    press("enter_4", 16'h8000, 3, mk(1, 0, 4'd15, 16'h0000, 3'd0, 1, 16'h0004, 3'd1));
    press("enter_empty", 16'h8000, 3, mk(1, 0, 4'd15, 16'h0000, 3'd0, 1, 16'h0000, 3'd0));

    // Key 8 held across reset.
    begin
      exp_t e;
      @(negedge clk);
      key_link = 16'h0100;
      e.cyc  = cyc + 1;
      e.obs  = mk(1, 0, 4'd8, 16'h0008, 3'd1, 0, 16'h0000, 3'd0);
      e.name = "pre_rst_d8";
      exp_q.push_back(e);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      repeat (2) @(negedge clk);
      check_zero("rst_held");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_zero("held8_after_rst");
      key_link = 16'h0000;
      repeat (2) @(negedge clk);
    end
    press("d9_after_rst", 16'h0200, 3, mk(1, 0, 4'd9, 16'h0009, 3'd1, 0, 16'h0000, 3'd0));

    repeat (5) @(negedge clk);
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumes the 16 debounced key levels from the keypad input stage (`key_link[15:0]`, one bit per key, high while held) and turns them into discrete key events and a 4-digit BCD entry buffer. It sits between the keypad front end and the application logic, for example PIN/code comparison and display.
- Detects each new single-key press and encodes it.
- Rejects multi-key chords.
- Handles digit entry, backspace, clear and enter.
- Delivers a completed entry with a one-cycle valid pulse.

## Interface
- `DIGITS`, default 4: entry buffer depth in BCD digits. Legal range is 1–4. `digits` and `entry_value` are always 16 bits; unused upper nibbles are 0.
- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `key_link` input 16: debounced key levels. Bits 0–9 are digits 0–9, 10 is backspace, 11 is clear, 12–14 are function keys, 15 is enter.
- `key_valid` output 1: one-cycle pulse per accepted press.
- `key_code` output 4: index of the last accepted key. Holds its value between pulses.
- `key_err` output 1: one-cycle pulse on a rejected press (chord, or digit while full).
- `digits` output 16: current BCD buffer. `[3:0]` holds the most recent digit.
- `count` output 3: number of digits held, 0..DIGITS.
- `entry_valid` output 1: one-cycle pulse on enter.
- `entry_value` output 16: buffer contents captured at enter. Held until the next enter.
- `entry_count` output 3: `count` captured at enter.

## Operation
- **FSM states:** IDLE (all keys released, armed) and HELD (waiting for all keys to be released).
- **Reset:**
  - The FSM resets into HELD, so a key held through reset is not accepted.
  - All outputs reset to 0.
- **IDLE, `key_link` == 0:** stay in IDLE.
- **IDLE, exactly one bit i set:** accept the press, pulse `key_valid`, set `key_code`=i, go to HELD.
- **IDLE, two or more bits set:** pulse `key_err`, no `key_valid`, buffer unchanged, go to HELD.
- **HELD:** go to IDLE when `key_link` == 0. Any other key changes are ignored, so there is no rollover.
- **Actions on an accepted key i:**
  - Digit (0–9), `count` < DIGITS: `digits` ← {`digits`[11:0], i}; `count`+1. Bits above 4·DIGITS are forced to 0.
  - Digit, `count` == DIGITS: buffer unchanged. `key_valid` and `key_err` both pulse.
  - Backspace (10): `digits` ← {4'h0, `digits`[15:4]}; `count`−1. At `count` 0 there is no change and no error.
  - Clear (11): `digits` ← 0, `count` ← 0.
  - Function keys (12–14): `key_valid`/`key_code` only, buffer unchanged.
  - Enter (15):
    - `entry_value` ← `digits` and `entry_count` ← `count` (pre-clear values).
    - Pulse `entry_valid`.
    - `digits` ← 0, `count` ← 0.
    - Enter at `count` 0 is legal and yields `entry_value`=0, `entry_count`=0.
- **Key-to-code map:** priority and chord handling use the one-hot check only. No priority encoding of chords.

## Timing
- **Press latency:** when `key_link` goes one-hot in IDLE at cycle N, then at cycle N+1 all of the following are present together:
  - the `key_valid` and/or `key_err` pulse;
  - the updated `key_code`;
  - the updated `digits`/`count`;
  - the `entry_*` outputs.
- **Pulse width:** each pulse is exactly one cycle, regardless of how long the key is held.
- **Re-arm:** the first cycle with `key_link` == 0 in HELD moves the FSM to IDLE at the next edge. A new press is accepted at the earliest one cycle after that, so back-to-back presses need at least one all-released cycle between them.
- **Asynchronous reset mid-operation:**
  - Outputs clear immediately, including pulses in flight.
  - Any partial entry is discarded.
  - After deassertion the FSM is in HELD and needs `key_link` == 0 before accepting a press.
- **No combinational path** from `key_link` to any output.

## Test plan
- Press and release 1, 2, 3, 4, then enter, each key held for 5 cycles:
  - one `key_valid` pulse per press, each one cycle after the press;
  - `digits`=16'h1234 and `count`=4 before enter;
  - on enter: `entry_valid` pulse, `entry_value`=16'h1234, `entry_count`=4, `digits`=0, `count`=0.
- Enter 5, 6, 7, 8, then 9 (full) → on the 9: `key_valid` and `key_err` both pulse; `digits` stays 16'h5678.
- Enter 7, 3, backspace, backspace, backspace → `digits` goes 16'h0007, 16'h0073, 16'h0007, 0, 0; `count` ends at 0; no `key_err`.
- Assert bits 2 and 5 in the same cycle → `key_err` pulse, no `key_valid`, buffer unchanged.
- Hold key 4, then add key 6 while 4 is still held, then release both → exactly one `key_valid` with `key_code`=4, nothing for 6, `digits`=16'h0004.
- Hold key 8 across `rst` assert and deassert:
  - all outputs are 0 during reset, and no event fires while 8 stays held;
  - after release, a press of 9 gives `digits`=16'h0009.
